// File: rtl/simmem_delay_releaser.sv
// rtl/simmem_delay_releaser.sv - per-slot simulated-latency countdown and release-enable generator
module simmem_delay_releaser #(
    parameter int NumSlots      = 16,
    parameter int SlotAddrWidth = $clog2(NumSlots),
    parameter int DelayWidth    = 8,
    parameter int MaxBurstLen   = 16,
    parameter int BurstLenWidth = $clog2(MaxBurstLen + 1),
    parameter int PendCntWidth  = $clog2(NumSlots + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     entry_valid_i,
    output logic                     entry_ready_o,
    input  logic [SlotAddrWidth-1:0] entry_addr_i,
    input  logic [DelayWidth-1:0]    entry_delay_i,
    input  logic [BurstLenWidth-1:0] entry_burst_len_i,
    output logic [NumSlots-1:0]      release_en_o,
    input  logic [NumSlots-1:0]      released_addr_onehot_i,
    output logic [PendCntWidth-1:0]  pending_cnt_o,
    output logic                     err_o
);

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_COUNTING,
        SLOT_RELEASABLE
    } slot_state_e;

    slot_state_e              state_q [NumSlots];
    slot_state_e              state_d [NumSlots];
    logic [DelayWidth-1:0]    cnt_q   [NumSlots];
    logic [DelayWidth-1:0]    cnt_d   [NumSlots];
    logic [BurstLenWidth-1:0] beats_q [NumSlots];
    logic [BurstLenWidth-1:0] beats_d [NumSlots];
    logic [PendCntWidth-1:0]  pending_q;
    logic [PendCntWidth-1:0]  pending_d;
    logic                     err_q;
    logic                     err_d;

    logic                     accept;
    logic [NumSlots-1:0]      beat_valid;
    logic                     spurious;
    logic                     multi_hot;
    logic [BurstLenWidth-1:0] load_beats;

    // Release enables and entry acceptance derived from current slot state
    always_comb begin
        release_en_o = '0;
        for (int i = 0; i < NumSlots; i++) begin
            release_en_o[i] = ((state_q[i] == SLOT_COUNTING) && (cnt_q[i] == '0)) ||
                              (state_q[i] == SLOT_RELEASABLE);
        end
        entry_ready_o = (int'(entry_addr_i) < NumSlots) &&
                        (state_q[entry_addr_i] == SLOT_IDLE);
    end

    assign accept     = entry_valid_i && entry_ready_o;
    assign beat_valid = released_addr_onehot_i & release_en_o;
    assign spurious   = |(released_addr_onehot_i & ~release_en_o);
    assign multi_hot  = $countones(released_addr_onehot_i) > 1;
    // A zero burst length is flagged but treated as a single beat so the slot can still drain
    assign load_beats = (entry_burst_len_i == '0) ? BurstLenWidth'(1) : entry_burst_len_i;

    // Per-slot next state, counter updates, pending count and sticky error
    always_comb begin
        pending_d = '0;
        for (int i = 0; i < NumSlots; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            beats_d[i] = beats_q[i];
            case (state_q[i])
                SLOT_IDLE: begin
                    if (accept && (entry_addr_i == SlotAddrWidth'(i))) begin
                        state_d[i] = SLOT_COUNTING;
                        cnt_d[i]   = entry_delay_i;
                        beats_d[i] = load_beats;
                    end
                end
                SLOT_COUNTING: begin
                    if (cnt_q[i] != '0) begin
                        cnt_d[i] = cnt_q[i] - DelayWidth'(1);
                    end else if (beat_valid[i] && (beats_q[i] <= BurstLenWidth'(1))) begin
                        state_d[i] = SLOT_IDLE;
                        beats_d[i] = '0;
                    end else begin
                        state_d[i] = SLOT_RELEASABLE;
                        if (beat_valid[i]) begin
                            beats_d[i] = beats_q[i] - BurstLenWidth'(1);
                        end
                    end
                end
                SLOT_RELEASABLE: begin
                    if (beat_valid[i]) begin
                        if (beats_q[i] <= BurstLenWidth'(1)) begin
                            state_d[i] = SLOT_IDLE;
                            beats_d[i] = '0;
                        end else begin
                            beats_d[i] = beats_q[i] - BurstLenWidth'(1);
                        end
                    end
                end
                default: begin
                    state_d[i] = SLOT_IDLE;
                end
            endcase
            if (state_d[i] != SLOT_IDLE) begin
                pending_d = pending_d + PendCntWidth'(1);
            end
        end
        err_d = err_q || spurious || multi_hot ||
                (accept && (entry_burst_len_i == '0));
    end

    // Slot registers with synchronous active-low reset discarding all in-flight entries
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumSlots; i++) begin
                state_q[i] <= SLOT_IDLE;
                cnt_q[i]   <= '0;
                beats_q[i] <= '0;
            end
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            for (int i = 0; i < NumSlots; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                beats_q[i] <= beats_d[i];
            end
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign pending_cnt_o = pending_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_simmem_delay_releaser.sv
// tb/tb_simmem_delay_releaser.sv - directed self-checking bench for simmem_delay_releaser
module tb_simmem_delay_releaser;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        entry_valid;
    logic        entry_ready;
    logic [3:0]  entry_addr;
    logic [7:0]  entry_delay;
    logic [4:0]  entry_burst_len;
    logic [15:0] release_en;
    logic [15:0] rel;
    logic [4:0]  pending_cnt;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    simmem_delay_releaser dut (
        .clk_i                  (clk),
        .rst_ni                 (rst_n),
        .entry_valid_i          (entry_valid),
        .entry_ready_o          (entry_ready),
        .entry_addr_i           (entry_addr),
        .entry_delay_i          (entry_delay),
        .entry_burst_len_i      (entry_burst_len),
        .release_en_o           (release_en),
        .released_addr_onehot_i (rel),
        .pending_cnt_o          (pending_cnt),
        .err_o                  (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [3:0] a, input logic [7:0] d, input logic [4:0] b);
        entry_valid     = 1'b1;
        entry_addr      = a;
        entry_delay     = d;
        entry_burst_len = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n           = 1'b0;
        entry_valid     = 1'b0;
        entry_addr      = '0;
        entry_delay     = '0;
        entry_burst_len = 5'd1;
        rel             = '0;
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
        check("reset_en", 32'(release_en), 32'h0);
        check("reset_pending", 32'(pending_cnt), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_ready", 32'(entry_ready), 32'd1);

        // Write-response timing: delay 5, enable rises T+6, release frees the slot
        offer(4'd3, 8'd5, 5'd1);
        #1;
        check("wr_ready", 32'(entry_ready), 32'd1);
        cyc();
        entry_valid = 1'b0;
        check("wr_pending_1", 32'(pending_cnt), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("wr_en_low_T%0d", k), 32'(release_en[3]), 32'd0);
            cyc();
        end
        check("wr_en_rise_T6", 32'(release_en[3]), 32'd1);
        for (int k = 0; k < 4; k++) cyc();
        check("wr_en_hold_T10", 32'(release_en[3]), 32'd1);
        rel = 16'h0008;
        cyc();
        rel = '0;
        check("wr_en_drop", 32'(release_en[3]), 32'd0);
        check("wr_pending_0", 32'(pending_cnt), 32'd0);
        check("wr_err", 32'(err), 32'd0);

        // Zero delay: enable next cycle, release, immediate re-accept
        offer(4'd0, 8'd0, 5'd1);
        cyc();
        entry_valid = 1'b0;
        check("zd_en", 32'(release_en[0]), 32'd1);
        rel = 16'h0001;
        cyc();
        rel = '0;
        check("zd_en_drop", 32'(release_en[0]), 32'd0);
        check("zd_pending_0", 32'(pending_cnt), 32'd0);
        offer(4'd0, 8'd0, 5'd1);
        #1;
        check("zd_reaccept_ready", 32'(entry_ready), 32'd1);
        cyc();
        entry_valid = 1'b0;
        check("zd_reaccept_pending", 32'(pending_cnt), 32'd1);
        check("zd_reaccept_en", 32'(release_en[0]), 32'd1);
        rel = 16'h0001;
        cyc();
        rel = '0;
        check("zd_reaccept_free", 32'(pending_cnt), 32'd0);

        // Read burst: delay 2, 4 beats with gaps
        offer(4'd7, 8'd2, 5'd4);
        cyc();
        entry_valid = 1'b0;
        check("rb_en_T1", 32'(release_en[7]), 32'd0);
        cyc();
        check("rb_en_T2", 32'(release_en[7]), 32'd0);
        cyc();
        check("rb_en_T3", 32'(release_en[7]), 32'd1);
        rel = 16'h0080;
        cyc();
        rel = '0;
        check("rb_en_T4", 32'(release_en[7]), 32'd1);
        cyc();
        rel = 16'h0080;
        cyc();
        cyc();
        rel = '0;
        check("rb_en_T7", 32'(release_en[7]), 32'd1);
        check("rb_pending_T7", 32'(pending_cnt), 32'd1);
        cyc();
        cyc();
        check("rb_en_T9", 32'(release_en[7]), 32'd1);
        rel = 16'h0080;
        cyc();
        rel = '0;
        check("rb_en_drop", 32'(release_en[7]), 32'd0);
        check("rb_pending_0", 32'(pending_cnt), 32'd0);
        check("rb_err", 32'(err), 32'd0);

        // Busy slot rejected, different slot accepted
        offer(4'd2, 8'd10, 5'd1);
        cyc();
        #1;
        check("busy_ready", 32'(entry_ready), 32'd0);
        cyc();
        check("busy_pending", 32'(pending_cnt), 32'd1);
        offer(4'd5, 8'd10, 5'd1);
        #1;
        check("other_ready", 32'(entry_ready), 32'd1);
        cyc();
        entry_valid = 1'b0;
        check("other_pending", 32'(pending_cnt), 32'd2);

        // Fill all slots, then reset mid-operation
        do_reset();
        check("fill_pre_pending", 32'(pending_cnt), 32'd0);
        for (int a = 0; a < 16; a++) begin
            offer(4'(a), 8'd255, 5'd1);
            cyc();
        end
        entry_valid = 1'b0;
        check("full_pending", 32'(pending_cnt), 32'd16);
        entry_addr = 4'd0;
        #1;
        check("full_ready_0", 32'(entry_ready), 32'd0);
        entry_addr = 4'd15;
        #1;
        check("full_ready_15", 32'(entry_ready), 32'd0);
        check("full_en", 32'(release_en), 32'h0);
        do_reset();
        check("rst_en", 32'(release_en), 32'h0);
        check("rst_pending", 32'(pending_cnt), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        offer(4'd4, 8'd3, 5'd1);
        #1;
        check("rst_ready", 32'(entry_ready), 32'd1);
        cyc();
        entry_valid = 1'b0;
        check("rst_accept_pending", 32'(pending_cnt), 32'd1);

        // Spurious release on an idle slot sets sticky error, state unchanged
        rel = 16'h0200;
        #1;
        check("sp_err_before", 32'(err), 32'd0);
        cyc();
        rel = '0;
        check("sp_err_set", 32'(err), 32'd1);
        cyc();
        cyc();
        cyc();
        check("sp_err_held", 32'(err), 32'd1);
        check("sp_pending", 32'(pending_cnt), 32'd1);
        entry_addr = 4'd9;
        #1;
        check("sp_slot9_idle", 32'(entry_ready), 32'd1);
        check("sp_en9", 32'(release_en[9]), 32'd0);

        // Zero burst length: error, treated as a single beat
        do_reset();
        offer(4'd1, 8'd0, 5'd0);
        cyc();
        entry_valid = 1'b0;
        check("b0_err", 32'(err), 32'd1);
        check("b0_en", 32'(release_en[1]), 32'd1);
        rel = 16'h0002;
        cyc();
        rel = '0;
        check("b0_en_drop", 32'(release_en[1]), 32'd0);
        check("b0_pending", 32'(pending_cnt), 32'd0);

        // Multi-hot release flags an error
        do_reset();
        offer(4'd6, 8'd0, 5'd2);
        cyc();
        offer(4'd8, 8'd0, 5'd2);
        cyc();
        entry_valid = 1'b0;
        check("mh_err_before", 32'(err), 32'd0);
        rel = 16'h0140;
        cyc();
        rel = '0;
        check("mh_err", 32'(err), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
